// File: rtl/mcu_el2_ifu_fetch_buf_if.sv
// ---------------------------------------------------------------------------
// mcu_el2_ifu_fetch_buf_if
//   Bundle of every signal between the IFU fetch buffer and its neighbours:
//   the fetch-pipe controller (fetch groups in, consume indications out) and
//   the aligner (two oldest entries out, pop requests in).
//
//   Fetch side : exu_flush_final, ic_data_valid_f, ic_data_f,
//                ifc_fetch_addr_f[31:1], ic_access_fault_f,
//                ifu_fb_consume1, ifu_fb_consume2
//   Aligner    : aln_pop1, aln_pop2,
//                fb{0,1}_valid/_data/_pc/_hw_valid/_fault
//   Status     : fb_count (occupancy), fb_overflow_err (sticky drop flag)
//
//   master : the environment driving fetch groups and pops
//   slave  : the fetch buffer itself
// ---------------------------------------------------------------------------
interface mcu_el2_ifu_fetch_buf_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic              exu_flush_final;
   logic              ic_data_valid_f;
   logic [63:0]       ic_data_f;
   logic [31:1]       ifc_fetch_addr_f;
   logic              ic_access_fault_f;
   logic              aln_pop1;
   logic              aln_pop2;

   logic              fb0_valid;
   logic              fb1_valid;
   logic [63:0]       fb0_data;
   logic [63:0]       fb1_data;
   logic [31:1]       fb0_pc;
   logic [31:1]       fb1_pc;
   logic [3:0]        fb0_hw_valid;
   logic [3:0]        fb1_hw_valid;
   logic              fb0_fault;
   logic              fb1_fault;
   logic              ifu_fb_consume1;
   logic              ifu_fb_consume2;
   logic [CNT_W-1:0]  fb_count;
   logic              fb_overflow_err;

   modport master (
      output exu_flush_final, ic_data_valid_f, ic_data_f, ifc_fetch_addr_f,
             ic_access_fault_f, aln_pop1, aln_pop2,
      input  fb0_valid, fb1_valid, fb0_data, fb1_data, fb0_pc, fb1_pc,
             fb0_hw_valid, fb1_hw_valid, fb0_fault, fb1_fault,
             ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_overflow_err
   );

   modport slave (
      input  exu_flush_final, ic_data_valid_f, ic_data_f, ifc_fetch_addr_f,
             ic_access_fault_f, aln_pop1, aln_pop2,
      output fb0_valid, fb1_valid, fb0_data, fb1_data, fb0_pc, fb1_pc,
             fb0_hw_valid, fb1_hw_valid, fb0_fault, fb1_fault,
             ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_overflow_err
   );
endinterface

// File: rtl/mcu_el2_ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// mcu_el2_ifu_fetch_buf
//   In-order fetch buffer between the IFU fetch-pipe controller and the
//   aligner. Each returned F-stage fetch group (64-bit data, PC, fault) is
//   captured into a DEPTH-entry shift queue whose entry 0 is always the
//   oldest. The two oldest entries are presented to the aligner, which may
//   retire 0, 1 or 2 of them per cycle; the retire count is reported back to
//   the fetch controller as ifu_fb_consume1/ifu_fb_consume2.
//
//   Ports
//     clk  : core clock
//     rst  : synchronous, active-high reset
//     bus  : slave side of mcu_el2_ifu_fetch_buf_if (fetch inputs, aligner
//            pops, entry 0/1 outputs, consume indications, status)
// ---------------------------------------------------------------------------
module mcu_el2_ifu_fetch_buf #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   mcu_el2_ifu_fetch_buf_if.slave  bus
);

   typedef struct packed {
      logic [63:0] data;
      logic [31:1] pc;
      logic [3:0]  hw;
      logic        fault;
   } fb_ent_t;

   fb_ent_t           ent_q [DEPTH];
   fb_ent_t           ent_d [DEPTH];
   fb_ent_t           new_ent;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q, err_d;

   logic [1:0]        req;
   logic [CNT_W-1:0]  pops;
   logic [CNT_W-1:0]  remain;
   logic              wr;
   logic              drop;

   // A fetch group starting mid-line only carries halfwords from PC[2:1] up.
   function automatic logic [3:0] hw_mask(input logic [1:0] off);
      return 4'(4'b1111 << off);
   endfunction

   // Pop resolution and write acceptance. pop2 dominates pop1, and the
   // request is clipped to what is actually held so the fetch controller is
   // never told about entries that did not exist.
   always_comb begin
      req = bus.aln_pop2 ? 2'd2 : (bus.aln_pop1 ? 2'd1 : 2'd0);
      if (CNT_W'(req) > count_q) pops = count_q;
      else                       pops = CNT_W'(req);
      remain = count_q - pops;
      // Pops free their slots before the write is considered, so a full
      // buffer still accepts a write in a cycle that also pops.
      wr   = bus.ic_data_valid_f & ~bus.exu_flush_final & (int'(remain) < DEPTH);
      drop = bus.ic_data_valid_f & ~bus.exu_flush_final & (int'(remain) == DEPTH);
   end

   // Next state: shift down by pops, then drop the new group in at the first
   // free slot. Flush empties the queue; stale payload is left in place.
   always_comb begin
      new_ent.data  = bus.ic_data_f;
      new_ent.pc    = bus.ifc_fetch_addr_f;
      new_ent.hw    = hw_mask(bus.ifc_fetch_addr_f[2:1]);
      new_ent.fault = bus.ic_access_fault_f;

      count_d = bus.exu_flush_final ? '0 : CNT_W'(remain + CNT_W'(wr));
      err_d   = err_q | drop;
      vld_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (!bus.exu_flush_final) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (j == i + int'(pops)) ent_d[i] = ent_q[j];
            end
            if (wr && (i == int'(remain))) ent_d[i] = new_ent;
         end
         vld_d[i] = (i < int'(count_d));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         vld_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         count_q <= count_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

   assign bus.fb0_valid       = vld_q[0];
   assign bus.fb1_valid       = vld_q[1];
   assign bus.fb0_data        = ent_q[0].data;
   assign bus.fb1_data        = ent_q[1].data;
   assign bus.fb0_pc          = ent_q[0].pc;
   assign bus.fb1_pc          = ent_q[1].pc;
   assign bus.fb0_hw_valid    = ent_q[0].hw;
   assign bus.fb1_hw_valid    = ent_q[1].hw;
   assign bus.fb0_fault       = ent_q[0].fault;
   assign bus.fb1_fault       = ent_q[1].fault;
   assign bus.fb_count        = count_q;
   assign bus.fb_overflow_err = err_q;

   // Retirements discarded by a flush must not be reported upstream.
   assign bus.ifu_fb_consume1 = ~bus.exu_flush_final & (pops == CNT_W'(1));
   assign bus.ifu_fb_consume2 = ~bus.exu_flush_final & (pops == CNT_W'(2));

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      int'(count_q) <= DEPTH);
   a_pops_bound: assert property (@(posedge clk) disable iff (rst)
      pops <= count_q);

endmodule
